ex_div: RTL and testbench

//  Multi-cycle RV32M divide/remainder unit beside the execute stage.

---
 rtl/ex_div.sv | 140 ++++++++++++++
 tb/tb_ex_div.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divider, one quotient bit per clock.
// Sign/zero/overflow cases are resolved at launch; ctrl can flush the operation in flight.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0]   result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_d;
  logic              nq_q, nq_d, nr_q, nr_d, is_rem_q, is_rem_d;

  // Launch decode: func3[0]=1 selects unsigned, func3[1]=1 selects remainder
  logic            sgn_c, s1_c, s2_c;
  logic [XLEN-1:0] abs1_c, abs2_c;
  assign sgn_c  = ~func3_i[0];
  assign s1_c   = sgn_c & op1_i[XLEN-1];
  assign s2_c   = sgn_c & op2_i[XLEN-1];
  assign abs1_c = s1_c ? -op1_i : op1_i;
  assign abs2_c = s2_c ? -op2_i : op2_i;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor
  logic [XLEN:0]   rem_sh_c;
  logic [XLEN+1:0] trial_c;
  logic            borrow_c;
  logic [XLEN-1:0] q_step_c, r_step_c;
  assign rem_sh_c = {rem_q, quo_q[XLEN-1]};
  assign trial_c  = {1'b0, rem_sh_c} - {2'b00, dvs_q};
  assign borrow_c = trial_c[XLEN+1];
  assign q_step_c = {quo_q[XLEN-2:0], ~borrow_c};
  assign r_step_c = borrow_c ? rem_sh_c[XLEN-1:0] : trial_c[XLEN-1:0];

  // trial bit XLEN is always 0 on a non-borrow step; func3[2] is 1 for every divide op
  logic unused_c;
  assign unused_c = ^{trial_c[XLEN], func3_i[2]};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    is_rem_d = is_rem_q;
    result_d = result_o;
    rd_d     = rd_addr_o;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rd_d     = rd_addr_i;
            is_rem_d = func3_i[1];
            if (op2_i == '0) begin
              result_d = func3_i[1] ? op1_i : '1;
              state_d  = DONE;
            end else if (sgn_c && op1_i == INT_MIN && op2_i == '1) begin
              result_d = func3_i[1] ? '0 : INT_MIN;
              state_d  = DONE;
            end else begin
              quo_d   = abs1_c;
              dvs_d   = abs2_c;
              rem_d   = '0;
              cnt_d   = '0;
              nq_d    = s1_c ^ s2_c;
              nr_d    = s1_c;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          quo_d = q_step_c;
          rem_d = r_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            if (is_rem_q) result_d = nr_q ? -r_step_c : r_step_c;
            else          result_d = nq_q ? -q_step_c : q_step_c;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_o    <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      nq_q      <= 1'b0;
      nr_q      <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_o    <= (state_d == CALC);
      result_o  <= result_d;
      rd_addr_o <= rd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      nq_q      <= nq_d;
      nr_q      <= nr_d;
      is_rem_q  <= is_rem_d;
    end
  end

  // A flush landing on DONE must kill that cycle's result strobe
  assign ready_o = (state_q == DONE) && !flush_i;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table for results/latency, plus flush, reset and
// start-while-busy sequences.
module tb_ex_div;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, start_i, flush_i;
  logic [2:0]  func3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int total = 0;
  int bad   = 0;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .func3_i(func3_i), .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a launch at the current (negedge) time; start is sampled on the next posedge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit keep);
    func3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start_i = 1'b0;
  endtask

  // Watch cycles 1..40 after launch; check latency, busy window, result, rd, one-cycle ready.
  task automatic wait_result(input string name, input int lat, input logic [31:0] exp,
                             input logic [4:0] rd);
    int rdy_cyc = 0;
    int busy_cnt = 0;
    logic busy_bad = 1'b0;
    for (int c = 1; c <= 40 && rdy_cyc == 0; c++) begin
      @(negedge clk);
      if (ready_o) rdy_cyc = c;
      if (busy_o) busy_cnt++;
      if (busy_o !== ((lat > 1) && (c < lat))) busy_bad = 1'b1;
    end
    chk({name, " latency"}, 32'(rdy_cyc), 32'(lat));
    chk({name, " busy cycles"}, 32'(busy_cnt), 32'(lat - 1));
    chk({name, " busy window"}, {31'd0, busy_bad}, 32'd0);
    if (rdy_cyc != 0) begin
      chk({name, " result"}, result_o, exp);
      chk({name, " rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    end
    @(negedge clk);
    chk({name, " ready one cycle"}, {31'd0, ready_o}, 32'd0);
  endtask

  // Count ready/busy over n cycles where neither should appear.
  task automatic expect_quiet(input string name, input int n);
    int rdy = 0;
    int bsy = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ready_o) rdy++;
      if (busy_o) bsy++;
    end
    chk({name, " no ready"}, 32'(rdy), 32'd0);
    chk({name, " no busy"}, 32'(bsy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{F_DIV,  32'hFFFF_FFF9, 32'd2,        5'd1,  32'hFFFF_FFFD, 33};
    vecs[1]  = '{F_REM,  32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF, 33};
    vecs[2]  = '{F_REMU, 32'd100,       32'd7,        5'd3,  32'd2,         33};
    vecs[3]  = '{F_DIVU, 32'd100,       32'd7,        5'd4,  32'd14,        33};
    vecs[4]  = '{F_DIVU, 32'd5,         32'd0,        5'd5,  32'hFFFF_FFFF, 1};
    vecs[5]  = '{F_REM,  32'd5,         32'd0,        5'd6,  32'd5,         1};
    vecs[6]  = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1};
    vecs[7]  = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0,         1};
    vecs[8]  = '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0,         33};
    vecs[9]  = '{F_DIV,  32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33};
    vecs[10] = '{F_REM,  32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,        33};
    vecs[11] = '{F_DIVU, 32'hFFFF_FFFF, 32'd1,        5'd12, 32'hFFFF_FFFF, 33};
    vecs[12] = '{F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd13, 32'd14,       33};
    vecs[13] = '{F_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFFE, 33};
    vecs[14] = '{F_DIV,  32'h8000_0000, 32'd2,        5'd15, 32'hC000_0000, 33};
    vecs[15] = '{F_REMU, 32'hFFFF_FFFF, 32'd10,       5'd31, 32'd5,         33};

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    func3_i = 3'b000; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    chk("reset ready", {31'd0, ready_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", {27'd0, rd_addr_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0);
      wait_result($sformatf("vec%0d", i), vecs[i].lat, vecs[i].exp, vecs[i].rd);
    end

    // flush beats a simultaneous start in IDLE
    func3_i = F_DIVU; op1_i = 32'd5; op2_i = 32'd0; rd_addr_i = 5'd20;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    expect_quiet("flush vs start", 5);

    // flush during DONE suppresses ready; result is already loaded and held
    launch(F_DIVU, 32'd5, 32'd0, 5'd21, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush in done ready", {31'd0, ready_o}, 32'd0);
    chk("flush in done result", result_o, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    expect_quiet("after done flush", 3);

    // flush in CALC cycle 10
    launch(F_DIV, 32'd1000, 32'd3, 5'd22, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("calc flush busy", {31'd0, busy_o}, 32'd0);
    chk("calc flush result held", result_o, 32'hFFFF_FFFF);
    expect_quiet("calc flush", 40);
    launch(F_DIVU, 32'd9, 32'd3, 5'd23, 1'b0);
    wait_result("after flush divu", 33, 32'd3, 5'd23);

    // start held high through CALC with other operands must not disturb the op
    launch(F_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
    func3_i = F_REMU; op1_i = 32'd55; op2_i = 32'd5; rd_addr_i = 5'd9;
    wait_result("start while busy", 33, 32'd14, 5'd3);
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    // async reset mid-CALC
    launch(F_DIVU, 32'd12345, 32'd11, 5'd17, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", {31'd0, busy_o}, 32'd0);
    chk("mid reset ready", {31'd0, ready_o}, 32'd0);
    chk("mid reset result", result_o, 32'd0);
    chk("mid reset rd", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("after reset", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
